// File: rtl/a2d_seq_pkg.sv
// Shared types and helpers for the periodic A2D sweep sequencer.
package a2d_seq_pkg;

    localparam int RES_W = 12;
    localparam int CH_W  = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        SETTLE     = 3'd2,
        WAIT_CMPLT = 3'd3,
        STORE      = 3'd4,
        DONE       = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] ch;
    } ch_sel_t;

    // Lowest set bit of mask at index >= from; pass idx+1 to get the next channel above idx.
    function automatic ch_sel_t next_set_bit(input logic [7:0] mask, input logic [3:0] from);
        ch_sel_t sel;
        sel = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                sel.found = 1'b1;
                sel.ch    = CH_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/a2d_period_timer.sv
// Free-running sweep period counter; held at zero while disabled.
module a2d_period_timer #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/a2d_sweep_seq.sv
// Periodic multi-channel A2D sweep sequencer with per-channel averaging
// and indexed result readback.
module a2d_sweep_seq
    import a2d_seq_pkg::*;
#(
    parameter logic [7:0] CH_MASK  = 8'h07,
    parameter int         PERIOD   = 50000,
    parameter int         AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cnv_cmplt,
    input  logic [RES_W-1:0] res,
    output logic             strt_cnv,
    output logic [CH_W-1:0]  chnnl,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [RES_W-1:0] rd_data,
    output logic [7:0]       ch_vld,
    output logic             sweep_done,
    output logic             ovr
);

    localparam int         ACC_W    = RES_W + AVG_LOG2;
    localparam logic [4:0] LAST_CNT = 5'((1 << AVG_LOG2) - 1);
    localparam ch_sel_t    FIRST_CH = next_set_bit(CH_MASK, 4'd0);

    seq_state_t       state;
    logic             tick;
    logic             en_q;
    logic             pending;
    logic [ACC_W-1:0] acc;
    logic [4:0]       cnt;
    logic [RES_W-1:0] result [8];
    ch_sel_t          nxt_ch;

    a2d_period_timer #(
        .PERIOD(PERIOD)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    assign nxt_ch     = next_set_bit(CH_MASK, {1'b0, chnnl} + 4'd1);
    assign strt_cnv   = (state == START);
    assign sweep_done = (state == DONE);
    assign rd_data    = result[rd_ch];

    // A new request (tick or enable rise) wins over IDLE consuming the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            pending <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            en_q <= en;
            ovr  <= ovr | (tick & pending);
            if (!en) begin
                pending <= 1'b0;
            end else if (tick || !en_q) begin
                pending <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            chnnl  <= '0;
            acc    <= '0;
            cnt    <= '0;
            ch_vld <= '0;
            for (int i = 0; i < 8; i++) begin
                result[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        chnnl <= FIRST_CH.ch;
                        state <= START;
                    end
                end
                START:  state <= SETTLE;
                // cnv_cmplt still reflects the previous conversion here.
                SETTLE: state <= WAIT_CMPLT;
                WAIT_CMPLT: begin
                    if (cnv_cmplt) begin
                        acc   <= acc + ACC_W'(res);
                        cnt   <= cnt + 5'd1;
                        state <= (cnt == LAST_CNT) ? STORE : START;
                    end
                end
                STORE: begin
                    result[chnnl] <= acc[ACC_W-1:AVG_LOG2];
                    ch_vld[chnnl] <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    if (nxt_ch.found) begin
                        chnnl <= nxt_ch.ch;
                        state <= START;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sweep_seq.sv
// Scoreboard bench for a2d_sweep_seq with a behavioural A2D model.
module tb_a2d_sweep_seq;

    localparam logic [7:0] MASK = 8'hA4;
    localparam int         PER  = 200;
    localparam int         AVG  = 2;

    typedef struct {
        bit         is_done;
        logic [2:0] ch;
        logic [7:0] vld;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
    logic [7:0]  ch_vld;
    logic        sweep_done;
    logic        ovr;

    logic [2:0]  rd_sel_stim = 3'd0;
    logic [2:0]  rd_sel_mon = 3'd0;
    logic        mon_active = 1'b0;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;

    // Averages of the model's samples: ch2 408/4, ch5 8200/4, ch7 16368/4.
    logic [11:0] exp_res [8] = '{12'd0, 12'd0, 12'd102, 12'd0, 12'd0, 12'h802, 12'd0, 12'hFFC};
    logic [2:0]  order [3] = '{3'd2, 3'd5, 3'd7};

    // A2D model state
    int          lat = 3;
    logic        busy;
    int          cd;
    logic [2:0]  m_ch;
    logic [1:0]  m_idx;
    logic [1:0]  sidx [8];
    bit          overlap = 1'b0;

    always #10 clk = ~clk;

    assign rd_ch = mon_active ? rd_sel_mon : rd_sel_stim;

    a2d_sweep_seq #(
        .CH_MASK (MASK),
        .PERIOD  (PER),
        .AVG_LOG2(AVG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .rd_ch     (rd_ch),
        .rd_data   (rd_data),
        .ch_vld    (ch_vld),
        .sweep_done(sweep_done),
        .ovr       (ovr)
    );

    function automatic logic [11:0] model_val(input logic [2:0] ch, input logic [1:0] idx);
        logic [11:0] base;
        logic [11:0] off;
        case (ch)
            3'd2:    base = 12'd100;
            3'd5:    base = 12'h800;
            3'd7:    base = 12'hFFA;
            default: base = 12'd0;
        endcase
        case (idx)
            2'd0:    off = 12'd0;
            2'd1:    off = 12'd1;
            2'd2:    off = 12'd2;
            default: off = 12'd5;
        endcase
        return base + off;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            cd        <= 0;
            cnv_cmplt <= 1'b0;
            res       <= 12'd0;
            m_ch      <= 3'd0;
            m_idx     <= 2'd0;
            for (int i = 0; i < 8; i++) sidx[i] <= 2'd0;
        end else if (strt_cnv) begin
            if (busy) overlap <= 1'b1;
            busy        <= 1'b1;
            cd          <= lat;
            cnv_cmplt   <= 1'b0;
            m_ch        <= chnnl;
            m_idx       <= sidx[chnnl];
            sidx[chnnl] <= sidx[chnnl] + 2'd1;
        end else if (busy) begin
            if (cd <= 1) begin
                busy      <= 1'b0;
                cnv_cmplt <= 1'b1;
                res       <= model_val(m_ch, m_idx);
            end else begin
                cd <= cd - 1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic push_sweep();
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            repeat (4) begin
                e.is_done = 1'b0;
                e.ch      = order[k];
                e.vld     = 8'h00;
                sb.push_back(e);
            end
        end
        e.is_done = 1'b1;
        e.ch      = 3'd0;
        e.vld     = 8'hA4;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c;
        c = 0;
        while (done_cnt < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        check("sweep_done_count", 32'(done_cnt), 32'(target));
    endtask

    // Cycles from the current point until strt_cnv is seen, bounded.
    task automatic cycles_to_strt(output int n, input int budget);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (strt_cnv) break;
        end
    endtask

    // Monitor: pops one expectation per DUT strt_cnv / sweep_done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (strt_cnv) begin
                    check("strt_has_expectation", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("strt_kind", 32'(mon_e.is_done), 32'd0);
                        check("strt_chnnl", 32'(chnnl), 32'(mon_e.ch));
                    end
                end
                if (sweep_done) begin
                    check("done_has_expectation", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        mon_e = sb.pop_front();
                        check("done_kind", 32'(mon_e.is_done), 32'd1);
                        check("done_ch_vld", 32'(ch_vld), 32'(mon_e.vld));
                    end
                    mon_active = 1'b1;
                    for (int i = 0; i < 8; i++) begin
                        rd_sel_mon = 3'(i);
                        #1;
                        check($sformatf("rd_data_ch%0d", i), 32'(rd_data), 32'(exp_res[i]));
                    end
                    mon_active = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strt_cnv", 32'(strt_cnv), 32'd0);
        check("rst_chnnl", 32'(chnnl), 32'd0);
        check("rst_ch_vld", 32'(ch_vld), 32'd0);
        check("rst_sweep_done", 32'(sweep_done), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full sparse sweep with averaging
        lat = 3;
        push_sweep();
        @(negedge clk);
        en = 1'b1;
        cycles_to_strt(n, 10);
        check("en_to_strt_cycles", 32'(n), 32'd2);
        wait_done(1, 400);
        @(negedge clk);
        en = 1'b0;
        check("sweep1_ovr", 32'(ovr), 32'd0);
        check("sweep1_queue_left", 32'(sb.size()), 32'd0);

        // Drop en while channel 5 is being converted
        push_sweep();
        @(negedge clk);
        en = 1'b1;
        n = 0;
        while (n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (strt_cnv && chnnl == 3'd5) break;
        end
        check("saw_ch5_strt", 32'(strt_cnv && chnnl == 3'd5), 32'd1);
        @(negedge clk);
        en = 1'b0;
        wait_done(2, 400);
        repeat (3 * PER) @(posedge clk);
        check("drop_en_queue_left", 32'(sb.size()), 32'd0);
        check("drop_en_done_count", 32'(done_cnt), 32'd2);

        // Overrun: sweep outlasts several periods
        lat = 40;
        push_sweep();
        push_sweep();
        @(negedge clk);
        en = 1'b1;
        wait_done(3, 1500);
        // wait_done returns on the edge ending DONE; IDLE then START follows.
        cycles_to_strt(n, 10);
        check("back_to_back_gap", 32'(n), 32'd1);
        @(negedge clk);
        en = 1'b0;
        wait_done(4, 1500);
        check("overrun_ovr", 32'(ovr), 32'd1);
        check("overrun_no_overlap", 32'(overlap), 32'd0);
        repeat (3 * PER) @(posedge clk);
        check("overrun_queue_left", 32'(sb.size()), 32'd0);

        // Reset in WAIT_CMPLT
        push_sweep();
        @(negedge clk);
        en = 1'b1;
        cycles_to_strt(n, 10);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        en    = 1'b0;
        sb.delete();
        #1;
        check("midrst_strt_cnv", 32'(strt_cnv), 32'd0);
        check("midrst_chnnl", 32'(chnnl), 32'd0);
        check("midrst_ch_vld", 32'(ch_vld), 32'd0);
        check("midrst_sweep_done", 32'(sweep_done), 32'd0);
        check("midrst_ovr", 32'(ovr), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_sel_stim = 3'(i);
            #1;
            check($sformatf("midrst_rd_data_ch%0d", i), 32'(rd_data), 32'd0);
        end
        rd_sel_stim = 3'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // Restart after reset begins at the lowest enabled channel
        lat = 3;
        push_sweep();
        @(negedge clk);
        en = 1'b1;
        cycles_to_strt(n, 10);
        check("restart_en_to_strt", 32'(n), 32'd2);
        check("restart_chnnl", 32'(chnnl), 32'd2);
        wait_done(5, 400);
        @(negedge clk);
        en = 1'b0;
        repeat (20) @(posedge clk);
        check("restart_queue_left", 32'(sb.size()), 32'd0);
        check("final_no_overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
